// File: rtl/assert_increment_range_if.sv
// assert_increment_range_if: groups the checker's sampled inputs and its fire/coverage outputs.
interface assert_increment_range_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             enable;
  logic             xzcheck_enable;
  logic [WIDTH-1:0] test_expr;
  logic [2:0]       fire;
  logic             error_seen;
  logic [CNT_W-1:0] cov_changes;
  logic [CNT_W-1:0] cov_max_hits;
  modport master (
    output enable, xzcheck_enable, test_expr,
    input  fire, error_seen, cov_changes, cov_max_hits
  );
  modport slave (
    input  enable, xzcheck_enable, test_expr,
    output fire, error_seen, cov_changes, cov_max_hits
  );
endinterface

// File: rtl/assert_increment_range.sv
// assert_increment_range: checks every change of test_expr is an increment in [MIN_INC, MAX_INC].
// Coverage counters are compiled only when OVL_INCREMENT_COVER_EN is defined; otherwise they read 0.
module assert_increment_range #(
  parameter int WIDTH   = 8,
  parameter int MIN_INC = 1,
  parameter int MAX_INC = 1,
  parameter int WRAP    = 0,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic reset_n,
  assert_increment_range_if.slave bus
);
  typedef enum logic {IDLE, ARMED} state_e;
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_INC);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_INC);
  if (MIN_INC < 1 || MIN_INC > MAX_INC) begin : g_bad_params
    $error("assert_increment_range: MIN_INC must be >= 1 and <= MAX_INC");
  end
  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] delta;
  logic [2:0]       fire_d, fire_q;
  logic             err_q, known, changed, dec, oor;
  always_comb begin
    known   = !$isunknown(bus.test_expr);
    delta   = bus.test_expr - prev_q;
    changed = state_q == ARMED && bus.enable && known && bus.test_expr != prev_q;
    dec     = changed && WRAP == 0 && bus.test_expr < prev_q;
    oor     = changed && !dec && (delta < MIN_V || delta > MAX_V);
    fire_d  = {bus.enable && bus.xzcheck_enable && !known, dec, oor};
  end
  // An X/Z sample drops the reference; an unchecked X/Z sample leaves everything untouched.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      fire_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      fire_q <= fire_d;
      err_q  <= err_q | (|fire_d);
      if (fire_d[2]) state_q <= IDLE;
      else if (bus.enable && known) begin
        state_q <= ARMED;
        prev_q  <= bus.test_expr;
      end
    end
  end
  assign bus.fire       = fire_q;
  assign bus.error_seen = err_q;
`ifdef OVL_INCREMENT_COVER_EN
  logic             legal_chg;
  logic [CNT_W-1:0] chg_q, max_q;
  assign legal_chg = changed && !dec && !oor;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      chg_q <= '0;
      max_q <= '0;
    end else begin
      if (legal_chg && !(&chg_q)) chg_q <= chg_q + CNT_W'(1);
      if (legal_chg && delta == MAX_V && !(&max_q)) max_q <= max_q + CNT_W'(1);
    end
  end
  assign bus.cov_changes  = chg_q;
  assign bus.cov_max_hits = max_q;
`else
  assign bus.cov_changes  = '0;
  assign bus.cov_max_hits = '0;
`endif
endmodule
